md_issue: RTL

MD_ISSUE -- requirements
Module: md_issue

---
 rtl/md_issue_pkg.sv | 42 ++++
 rtl/md_latency_counter.sv | 48 ++++
 rtl/md_issue.sv | 96 +++++++++
 3 files changed

// File: rtl/md_issue_pkg.sv
// -----------------------------------------------------------------------------
// md_issue_pkg
// Shared definitions for the multiply/divide issue path: MDOp encodings used by
// the decoder, the issue block and the MDU, plus the default MDU latencies and
// small opcode classification helpers.
// -----------------------------------------------------------------------------
package md_issue_pkg;

    localparam int MDOP_W = 4;
    localparam int CNT_W  = 4;

    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    typedef enum logic [MDOP_W-1:0] {
        MD_MFHI  = 4'd0,
        MD_MFLO  = 4'd1,
        MD_MTHI  = 4'd2,
        MD_MTLO  = 4'd3,
        MD_MULT  = 4'd4,
        MD_MULTU = 4'd5,
        MD_DIV   = 4'd6,
        MD_DIVU  = 4'd7,
        MD_NONE  = 4'd15
    } md_op_e;

    // Any real MD instruction (0..7); 8..15 all mean "no MD op".
    function automatic logic is_md_op(input logic [MDOP_W-1:0] op);
        return op[3] == 1'b0;
    endfunction

    // Opcodes that start the MDU: mult, multu, div, divu.
    function automatic logic is_start_op(input logic [MDOP_W-1:0] op);
        return op[3:2] == 2'b01;
    endfunction

    // div/divu take the long latency; mult/multu the short one.
    function automatic logic is_div_op(input logic [MDOP_W-1:0] op);
        return op[3:1] == 3'b011;
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// -----------------------------------------------------------------------------
// md_latency_counter
// Mirror of the MDU busy time. Loads load_val on load_en, otherwise counts
// down to zero and holds there. busy is high while the count is nonzero.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   load_en  : load the counter this edge
//   load_val : latency to load
//   cnt      : current count
//   busy     : cnt != 0
// -----------------------------------------------------------------------------
module md_latency_counter
    import md_issue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_en) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignment in clocked blocks so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/md_issue.sv
// -----------------------------------------------------------------------------
// md_issue
// Issue/interlock logic for the multiply/divide slot between D and E. Holds
// the D->E register for MD ops, pulses e_start to the MDU, mirrors the MDU
// busy time and stalls any MD instruction in D while a result is pending.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   d_valid  : D-stage instruction valid
//   d_mdop   : D-stage MD opcode (md_op_e; 8..15 = none)
//   flush    : kill the instruction entering E this cycle
//   mdu_busy : busy flag from the MDU
//   stall    : freeze PC and F/D, bubble into E
//   e_valid  : E-stage MD slot live
//   e_mdop   : E-stage opcode to the MDU
//   e_start  : MDU start pulse
//   sync_err : sticky, mirror disagreed with mdu_busy
// -----------------------------------------------------------------------------
module md_issue
    import md_issue_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [MDOP_W-1:0] d_mdop,
    input  logic              flush,
    input  logic              mdu_busy,
    output logic              stall,
    output logic              e_valid,
    output logic [MDOP_W-1:0] e_mdop,
    output logic              e_start,
    output logic              sync_err
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    logic              e_valid_d, e_valid_q;
    logic [MDOP_W-1:0] e_mdop_d,  e_mdop_q;
    logic              armed_d,   armed_q;
    logic              sync_err_d, sync_err_q;

    logic              busy_int;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_load_val;

    // E can only hold a start op for one cycle: a start op in D always stalls
    // behind the one in E (e_start term), so E takes a bubble next edge.
    assign e_start      = e_valid_q && is_start_op(e_mdop_q);
    assign cnt_load_val = is_div_op(e_mdop_q) ? DIV_LOAD : MUL_LOAD;
    assign stall        = d_valid && is_md_op(d_mdop) && (busy_int || e_start || mdu_busy);

    md_latency_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_en  (e_start),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .busy     (busy_int)
    );

    always_comb begin
        e_valid_d = d_valid;
        e_mdop_d  = d_mdop;
        // flush and stall both produce the same bubble, so flush trivially wins.
        if (flush || stall) begin
            e_valid_d = 1'b0;
            e_mdop_d  = MD_NONE;
        end
        // The comparison is armed one edge after the first start, giving the
        // MDU its start edge before mdu_busy is expected to track the mirror.
        armed_d    = armed_q | e_start;
        sync_err_d = sync_err_q | (armed_q & (mdu_busy != busy_int));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid_q  <= 1'b0;
            e_mdop_q   <= MD_NONE;
            armed_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            e_valid_q  <= e_valid_d;
            e_mdop_q   <= e_mdop_d;
            armed_q    <= armed_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign e_valid  = e_valid_q;
    assign e_mdop   = e_mdop_q;
    assign sync_err = sync_err_q;

endmodule
